// File: rtl/div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : div_pkg                                                         |
// | Purpose  : Shared types and width constants for the sequential restoring   |
// |            divider (seq_div_unit) and its single-step datapath (div_step). |
// | Contents : state_t  - controller states (IDLE, CALC, DONE)                 |
// |            M_W      - divisor / remainder width                            |
// |            N_W      - dividend / quotient width (2*M_W)                    |
// |            CNT_W    - step counter width for N_W steps                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package div_pkg;

  localparam int M_W   = 32;
  localparam int N_W   = 64;
  localparam int CNT_W = $clog2(N_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : div_step                                                        |
// | Purpose  : One combinational restoring-division step. Shifts the next      |
// |            dividend bit into the partial remainder and subtracts the       |
// |            divisor when it fits.                                           |
// | Ports    : r_in    [M:0]   partial remainder before the step               |
// |            bit_in          next dividend bit (MSB first)                   |
// |            divisor [M-1:0] divisor                                         |
// |            r_out   [M:0]   partial remainder after the step                |
// |            q_bit           quotient bit produced by this step              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module div_step #(
  parameter int M = 32
) (
  input  logic [M:0]   r_in,
  input  logic         bit_in,
  input  logic [M-1:0] divisor,
  output logic [M:0]   r_out,
  output logic         q_bit
);

  // Full-width shift keeps r_in[M] in the compare. In normal operation the
  // partial remainder is always below the divisor, so that bit is zero and
  // the shifted value never exceeds M+1 significant bits.
  logic [M+1:0] shifted;

  assign shifted = {r_in, bit_in};
  assign q_bit   = (shifted >= {2'b00, divisor});

  // When the subtraction happens the true difference is below the divisor,
  // so computing it modulo 2^(M+1) on the low bits is exact.
  assign r_out   = q_bit ? (shifted[M:0] - {1'b0, divisor}) : shifted[M:0];

endmodule : div_step
`default_nettype wire

// File: rtl/seq_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_div_unit                                                    |
// | Purpose  : Sequential unsigned restoring divider, one quotient bit per     |
// |            clock, valid/ready handshakes on operands and result.           |
// | Ports    : clk, rst_n (synchronous, active low)                            |
// |            in_valid / in_ready, dividend [N-1:0], divisor [M-1:0]          |
// |            out_valid / out_ready, quotient [N-1:0], remainder [M-1:0],     |
// |            div_by_zero (qualified by out_valid)                            |
// | Options  : DIV_ZERO_CHK_EN - when defined, a zero divisor skips the        |
// |            iteration and returns all-ones quotient with div_by_zero=1 one  |
// |            cycle after acceptance. Otherwise div_by_zero is tied low.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seq_div_unit
  import div_pkg::*;
#(
  parameter int M = M_W,
  parameter int N = N_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero
);

  localparam int STEP_CNT_W = $clog2(N);

  state_t                state_q,     state_d;
  logic                  in_ready_q,  in_ready_d;
  logic                  out_valid_q, out_valid_d;
  // quo_q starts as the dividend and is shifted left every step; quotient
  // bits enter at the bottom while dividend bits leave at the top.
  logic [N-1:0]          quo_q,       quo_d;
  logic [M:0]            rem_q,       rem_d;
  logic [M-1:0]          dvs_q,       dvs_d;
  logic [STEP_CNT_W-1:0] cnt_q,       cnt_d;

  logic [M:0]            step_r;
  logic                  step_q;

  div_step #(
    .M (M)
  ) u_step (
    .r_in    (rem_q),
    .bit_in  (quo_q[N-1]),
    .divisor (dvs_q),
    .r_out   (step_r),
    .q_bit   (step_q)
  );

`ifdef DIV_ZERO_CHK_EN
  logic dbz_q, dbz_d;
`endif

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
`ifdef DIV_ZERO_CHK_EN
    dbz_d       = dbz_q;
`endif

    case (state_q)
      IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          dvs_d      = divisor;
          quo_d      = dividend;
          rem_d      = '0;
          cnt_d      = '0;
          state_d    = CALC;
`ifdef DIV_ZERO_CHK_EN
          dbz_d      = 1'b0;
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = {1'b0, dividend[M-1:0]};
            dbz_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end

      CALC: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        quo_d       = {quo_q[N-2:0], step_q};
        rem_d       = step_r;
        cnt_d       = cnt_q + STEP_CNT_W'(1);
        if (cnt_q == STEP_CNT_W'(N - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // out_valid is registered, so it rises on the edge after entry.
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
`ifdef DIV_ZERO_CHK_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
`ifdef DIV_ZERO_CHK_EN
      dbz_q       <= dbz_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quo_q;
  assign remainder = rem_q[M-1:0];

`ifdef DIV_ZERO_CHK_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule : seq_div_unit
`default_nettype wire

// File: tb/tb_seq_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seq_div_unit                                                 |
// | Purpose  : Self-checking bench for seq_div_unit: directed vector table,    |
// |            backpressure / abort sequences and randomized operands checked  |
// |            against plain-arithmetic expectations.                          |
// | Options  : DIV_ZERO_CHK_EN - selects the zero-divisor expectations.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_seq_div_unit;

`ifdef DIV_ZERO_CHK_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  localparam int LAT = 65;   // accept edge to out_valid, in clock edges

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_div_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: unsigned division by plain arithmetic, with the zero-divisor
  // result defined as all-ones quotient and low dividend bits as remainder.
  function automatic logic [63:0] ref_q(input logic [63:0] a, input logic [31:0] b);
    if (b == 32'd0) return 64'hFFFF_FFFF_FFFF_FFFF;
    return a / {32'd0, b};
  endfunction

  function automatic logic [31:0] ref_r(input logic [63:0] a, input logic [31:0] b);
    logic [63:0] t;
    if (b == 32'd0) return a[31:0];
    t = a % {32'd0, b};
    return t[31:0];
  endfunction

  // Entered and left at a falling edge.
  task automatic run_op(input logic [63:0] a, input logic [31:0] b,
                        input logic [63:0] eq, input logic [31:0] er,
                        input int hold, input string tag);
    int  lat;
    int  elat;
    int  guard;
    logic edbz;
    edbz = (b == 32'd0) && DZ;
    elat = edbz ? 1 : LAT;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = $urandom;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"},   64'(lat),            64'(elat));
    chk({tag, ".quotient"},  quotient,            eq);
    chk({tag, ".remainder"}, {32'd0, remainder},  {32'd0, er});
    chk({tag, ".dbz"},       {63'd0, div_by_zero}, {63'd0, edbz});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, ".hold_ready"}, {63'd0, in_ready},  64'd0);
      chk({tag, ".hold_q"},     quotient,           eq);
      chk({tag, ".hold_r"},     {32'd0, remainder}, {32'd0, er});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".post_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, ".post_ready"}, {63'd0, in_ready},  64'd1);
    @(negedge clk);
  endtask

  typedef struct {
    logic [63:0] dvd;
    logic [31:0] dvs;
    logic [63:0] q;
    logic [31:0] r;
    string       name;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [63:0] ra, rb, prod;
    logic [63:0] a;
    logic [31:0] b;
    bit          seen;

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    dividend  = 64'd100;
    divisor   = 32'd7;
    out_ready = 1'b0;

    ra   = 64'h0000_0000_DB93_BBDB;
    rb   = 64'h0000_0000_BBDB_83DB;
    prod = ra * rb;

    vecs[0] = '{64'd100, 32'd7, 64'd14, 32'd2, "basic"};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF,
                64'h0000_0001_0000_0001, 32'd0, "max"};
    vecs[2] = '{prod, 32'hBBDB_83DB, 64'h0000_0000_DB93_BBDB, 32'd0, "roundtrip"};
    vecs[3] = '{64'd5, 32'd9, 64'd0, 32'd5, "small"};
    vecs[4] = '{64'h1234_5678_9ABC_DEF0, 32'd0,
                64'hFFFF_FFFF_FFFF_FFFF, 32'h9ABC_DEF0, "divzero"};

    // Reset held with in_valid asserted: nothing may be accepted.
    repeat (3) @(posedge clk);
    #1;
    chk("reset.in_ready",  {63'd0, in_ready},  64'd1);
    chk("reset.out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset.quotient",  quotient,           64'd0);
    chk("reset.remainder", {32'd0, remainder}, 64'd0);
    chk("reset.dbz",       {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    chk("reset.still_idle", {63'd0, in_ready}, 64'd1);
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, 0, vecs[i].name);
    end

    // Backpressure: result held for 5 cycles with out_ready low.
    run_op(64'd100, 32'd7, 64'd14, 32'd2, 5, "backpressure");

    // Abort at step 20 of CALC.
    dividend = 64'd100;
    divisor  = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort.in_ready",  {63'd0, in_ready},  64'd1);
    chk("abort.quotient",  quotient,           64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort.no_output", {63'd0, seen}, 64'd0);
    @(negedge clk);
    run_op(64'd100, 32'd7, 64'd14, 32'd2, 0, "after_abort");

    // Randomized operands against the arithmetic reference.
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 64'($urandom_range(0, 1000));
        1:       a = {32'd0, $urandom};
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(1, 255));
        1:       b = {16'd0, 16'($urandom)};
        default: b = $urandom;
      endcase
      if (i % 8 == 7) b = 32'd0;
      run_op(a, b, ref_q(a, b), ref_r(a, b), (i % 5 == 0) ? 2 : 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule : tb_seq_div_unit
`default_nettype wire

// File: doc/seq_div_unit.md
Name: seq_div_unit

Overview:
- Sequential restoring divider; the inverse companion to the team's combinational Karatsuba multiplier. Takes an n-bit dividend and an m-bit divisor and produces an n-bit quotient and an m-bit remainder.
- One quotient bit per clock; valid/ready handshakes on input and output.
- Verification use: round-trip check of multiplier products (C / B == A, remainder 0).

Parameters:
- m, 32, divisor and remainder width
- n, 64, dividend and quotient width; must equal 2*m

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- dividend  input  n  dividend
- divisor  input  m  divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  n  quotient
- remainder  output  m  remainder
- div_by_zero  output  1  divisor was zero; qualified by out_valid

Behaviour:
- Reset (rst_n low at a clk edge) values: state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, step counter=0.
- Reset mid-operation aborts the operation. The result is discarded and nothing is emitted.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch dividend and divisor, clear partial remainder (m+1 bits), counter=0, go to CALC.
  - CALC: in_ready=0, out_valid=0. Each cycle:
    - r = {r[m-1:0], q[n-1]}; q = q<<1.
    - If r >= {1'b0,divisor}, then r = r - divisor and q[0]=1.
    - Counter increments. After step n-1 (the n-th step), go to DONE.
  - DONE: out_valid=1. Outputs remain stable while out_ready=0. On out_valid&out_ready, go to IDLE (in_ready=1 the next cycle).
- Latency:
  - Accept edge at cycle T; CALC occupies cycles T+1..T+n; out_valid=1 from cycle T+n+1.
  - No overlap: a new operand is accepted no earlier than the cycle after the output handshake.
- Inputs are ignored outside IDLE. Operands need not be held after acceptance.
- Arithmetic:
  - Unsigned only. The quotient is always representable in n bits because the dividend is n bits.
  - Remainder < divisor whenever divisor != 0.
  - dividend < divisor gives quotient=0, remainder=dividend[m-1:0].
- Divisor = 0 without the optional feature: the algorithm runs all n steps naturally. Result is quotient = all ones, remainder = dividend[m-1:0], div_by_zero=0.

Optional Feature:
- Macro: DIV_ZERO_CHK_EN.
- Defined:
  - IDLE detects divisor==0 at acceptance and goes directly to DONE, bypassing CALC.
  - out_valid=1 at cycle T+1.
  - quotient = all ones, remainder = dividend[m-1:0], div_by_zero=1.
  - Nonzero divisors behave identically to the undefined case.
- Undefined: no detection logic; div_by_zero is tied to 0; divide-by-zero takes the full n+1 cycle latency.

Decomposition:
- Package div_pkg:
  - state enum (IDLE, CALC, DONE)
  - width constants M_W=32, N_W=64
  - counter width localparam CNT_W=$clog2(N_W)
- Sub-module div_step: combinational single restoring step.
  - Inputs: r (m+1 bits), incoming dividend bit, divisor.
  - Outputs: next r and the quotient bit.
  - Instantiated once; it is reused every CALC cycle.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=1, out_valid=0, quotient=0, remainder=0. No acceptance occurs during reset.
- Basic: dividend=100, divisor=7, out_ready=1 -> out_valid rises exactly 65 cycles after the accept edge; quotient=14, remainder=2.
- Max: dividend=64'hFFFF_FFFF_FFFF_FFFF, divisor=32'hFFFF_FFFF -> quotient=64'h0000_0001_0000_0001, remainder=0.
- Round-trip and small dividend:
  - dividend=32'hDB93BBDB*32'hBBDB83DB, divisor=32'hBBDB83DB -> quotient=32'hDB93BBDB, remainder=0.
  - dividend=5, divisor=9 -> quotient=0, remainder=5.
- Backpressure and abort:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; the handshake then returns the block to IDLE.
  - rst_n=0 at step 20 of CALC -> out_valid never asserts; the next operation 100/7 is correct.
- Divide by zero: dividend=64'h1234_5678_9ABC_DEF0, divisor=0.
  - With DIV_ZERO_CHK_EN: out_valid at T+1, quotient all ones, remainder=32'h9ABC_DEF0, div_by_zero=1.
  - Without it: same quotient and remainder at T+65, div_by_zero=0.
